// File: rtl/abro_n_fsm.sv
// abro_n_fsm: "wait for all of N conditions" sequencer; emits O once every event has been seen.
// Defining ABRO_TIMEOUT_EN adds a COLLECT-state timeout counter and the timeout output.
module abro_n_fsm #(
    parameter int N              = 2,
    parameter int ORDERED        = 0,
    parameter int O_PULSE        = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         R,
    input  logic [N-1:0] ev,
    output logic         O,
    output logic [3:0]   State,
    output logic [N-1:0] seen
`ifdef ABRO_TIMEOUT_EN
    ,
    output logic         timeout
`endif
);

    localparam logic [3:0]   S_IDLE    = 4'b0001;
    localparam logic [3:0]   S_COLLECT = 4'b0010;
    localparam logic [3:0]   S_EMIT    = 4'b0100;
    localparam logic [3:0]   S_DONE    = 4'b1000;
    localparam logic [N-1:0] ALL_SEEN  = '1;

    if (N < 2 || N > 16) begin : g_bad_n
        $error("abro_n_fsm: N must be in 2..16");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("abro_n_fsm: TIMEOUT_CYCLES must be in 1..65535");
    end

    logic [3:0]   state_next;
    logic [N-1:0] acc;
    logic [N-1:0] seen_next;
    logic         o_next;
    int           seen_count;
`ifdef ABRO_TIMEOUT_EN
    logic [15:0]  cnt;
    logic [15:0]  cnt_next;
    logic         tmo_hit;
    logic         timeout_next;
`endif

    // Ordered mode only ever grows seen from bit 0 upward, so its popcount is the next index due.
    always_comb begin
        seen_count = 0;
        acc        = '0;
        for (int i = 0; i < N; i++) begin
            seen_count += int'(seen[i]);
        end
        if (ORDERED != 0) begin
            for (int i = 0; i < N; i++) begin
                if (i == seen_count) begin
                    acc[i] = ev[i];
                end
            end
        end else begin
            acc = ev & ~seen;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            State <= S_IDLE;
            seen  <= '0;
            O     <= 1'b0;
`ifdef ABRO_TIMEOUT_EN
            cnt     <= '0;
            timeout <= 1'b0;
`endif
        end else begin
            State <= state_next;
            seen  <= seen_next;
            O     <= o_next;
`ifdef ABRO_TIMEOUT_EN
            cnt     <= cnt_next;
            timeout <= timeout_next;
`endif
        end
    end

    // R forces the defaults (IDLE, seen cleared, counter cleared) regardless of state or events.
    always_comb begin
        state_next = S_IDLE;
        seen_next  = '0;
`ifdef ABRO_TIMEOUT_EN
        cnt_next = '0;
        tmo_hit  = 1'b0;
`endif
        if (!R) begin
            case (State)
                S_IDLE: begin
                    seen_next = seen | acc;
                    if (seen_next == ALL_SEEN) begin
                        state_next = S_EMIT;
                    end else if (acc != '0) begin
                        state_next = S_COLLECT;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
                S_COLLECT: begin
                    seen_next = seen | acc;
                    if (seen_next == ALL_SEEN) begin
                        state_next = S_EMIT;
                    end else begin
                        state_next = S_COLLECT;
`ifdef ABRO_TIMEOUT_EN
                        cnt_next = cnt + 16'd1;
                        if (cnt_next == 16'(TIMEOUT_CYCLES)) begin
                            state_next = S_IDLE;
                            seen_next  = '0;
                            cnt_next   = '0;
                            tmo_hit    = 1'b1;
                        end
`endif
                    end
                end
                S_EMIT: begin
                    seen_next  = seen;
                    state_next = S_DONE;
                end
                S_DONE: begin
                    seen_next  = seen;
                    state_next = S_DONE;
                end
                default: begin
                    state_next = S_IDLE;
                    seen_next  = '0;
                end
            endcase
        end
    end

    always_comb begin
        o_next = (state_next == S_EMIT) || ((O_PULSE == 0) && (state_next == S_DONE));
`ifdef ABRO_TIMEOUT_EN
        timeout_next = tmo_hit;
`endif
    end

endmodule

// File: tb/tb_abro_n_fsm.sv
// Bench for abro_n_fsm: directed scenarios on two configurations plus randomized
// traffic checked against a set-based reference model.
module tb_abro_n_fsm;

    typedef struct {
        int          n;
        bit          ord;
        bit          pulse;
        int          tlimit;
        logic [15:0] got;
        bit          emit;
        bit          fin;
        int          wait_cnt;
        bit          tmo;
    } model_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       a_r;
    logic [1:0] a_ev;
    logic       a_o;
    logic [3:0] a_state;
    logic [1:0] a_seen;
    logic       b_r;
    logic [2:0] b_ev;
    logic       b_o;
    logic [3:0] b_state;
    logic [2:0] b_seen;
    logic [6:0] a_obs;
    logic [7:0] b_obs;
    int         n_chk = 0;
    int         n_err = 0;

`ifdef ABRO_TIMEOUT_EN
    logic a_tmo;
    logic b_tmo;
    localparam int TLIM_A = 4;
    localparam int TLIM_B = 255;
`else
    localparam int TLIM_A = 0;
    localparam int TLIM_B = 0;
`endif

    assign a_obs = {a_state, a_seen, a_o};
    assign b_obs = {b_state, b_seen, b_o};

    abro_n_fsm #(.N(2), .ORDERED(0), .O_PULSE(1), .TIMEOUT_CYCLES(4)) dut_a (
        .clk(clk), .reset_n(reset_n), .R(a_r), .ev(a_ev),
        .O(a_o), .State(a_state), .seen(a_seen)
`ifdef ABRO_TIMEOUT_EN
        , .timeout(a_tmo)
`endif
    );

    abro_n_fsm #(.N(3), .ORDERED(1), .O_PULSE(0), .TIMEOUT_CYCLES(255)) dut_b (
        .clk(clk), .reset_n(reset_n), .R(b_r), .ev(b_ev),
        .O(b_o), .State(b_state), .seen(b_seen)
`ifdef ABRO_TIMEOUT_EN
        , .timeout(b_tmo)
`endif
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // drivers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // reference model: tracks the set of events seen, completion and the collect wait
    function automatic int count_ones(logic [15:0] v);
        int c = 0;
        for (int i = 0; i < 16; i++) c += int'(v[i]);
        return c;
    endfunction

    function automatic model_t model_init(int n, bit ord, bit pulse, int tlimit);
        model_t m;
        m.n = n; m.ord = ord; m.pulse = pulse; m.tlimit = tlimit;
        m.got = '0; m.emit = 1'b0; m.fin = 1'b0; m.wait_cnt = 0; m.tmo = 1'b0;
        return m;
    endfunction

    function automatic model_t model_step(model_t m, bit r, logic [15:0] e);
        int have;
        bit was_waiting;
        logic [15:0] mask;
        m.tmo = 1'b0;
        if (r) begin
            m.got = '0; m.emit = 1'b0; m.fin = 1'b0; m.wait_cnt = 0;
            return m;
        end
        if (m.emit) begin
            m.emit = 1'b0; m.fin = 1'b1;
            return m;
        end
        if (m.fin) return m;
        was_waiting = (m.got != '0);
        have = count_ones(m.got);
        mask = (16'd1 << m.n) - 16'd1;
        if (m.ord) begin
            if (e[have]) m.got[have] = 1'b1;
        end else begin
            m.got = m.got | (e & mask);
        end
        if (count_ones(m.got) == m.n) begin
            m.emit = 1'b1;
            m.wait_cnt = 0;
        end else if (was_waiting) begin
            m.wait_cnt++;
            if (m.tlimit > 0 && m.wait_cnt == m.tlimit) begin
                m.got = '0; m.wait_cnt = 0; m.tmo = 1'b1;
            end
        end else begin
            m.wait_cnt = 0;
        end
        return m;
    endfunction

    function automatic logic [3:0] exp_state(model_t m);
        if (m.emit) return 4'b0100;
        if (m.fin) return 4'b1000;
        if (m.got != '0) return 4'b0010;
        return 4'b0001;
    endfunction

    function automatic logic exp_o(model_t m);
        return m.emit || (m.fin && !m.pulse);
    endfunction

    // scenarios
    task automatic test_reset();
        reset_n = 1'b0;
        a_r = 1'b0; b_r = 1'b0; a_ev = 2'b11; b_ev = 3'b111;
        tick();
        tick();
        n_chk++; if (a_obs !== 7'b0001_00_0) begin n_err++; $display("FAIL reset_a: got State/seen/O=%b want %b", a_obs, 7'b0001_00_0); end
        n_chk++; if (b_obs !== 8'b0001_000_0) begin n_err++; $display("FAIL reset_b: got State/seen/O=%b want %b", b_obs, 8'b0001_000_0); end
`ifdef ABRO_TIMEOUT_EN
        n_chk++; if (a_tmo !== 1'b0) begin n_err++; $display("FAIL reset_tmo: got %b want 0", a_tmo); end
`endif
        a_ev = 2'b00; b_ev = 3'b000;
        reset_n = 1'b1;
        tick();
        n_chk++; if (a_obs !== 7'b0001_00_0) begin n_err++; $display("FAIL reset_release_a: got %b want %b", a_obs, 7'b0001_00_0); end
    endtask

    task automatic test_in_order();
        a_ev = 2'b00; tick();
        n_chk++; if (a_obs !== 7'b0001_00_0) begin n_err++; $display("FAIL in_order_idle: got %b want %b", a_obs, 7'b0001_00_0); end
        a_ev = 2'b01; tick();
        n_chk++; if (a_obs !== 7'b0010_01_0) begin n_err++; $display("FAIL in_order_collect: got %b want %b", a_obs, 7'b0010_01_0); end
        a_ev = 2'b10; tick();
        n_chk++; if (a_obs !== 7'b0100_11_1) begin n_err++; $display("FAIL in_order_emit: got %b want %b", a_obs, 7'b0100_11_1); end
        a_ev = 2'b00; tick();
        n_chk++; if (a_obs !== 7'b1000_11_0) begin n_err++; $display("FAIL in_order_done: got %b want %b", a_obs, 7'b1000_11_0); end
        a_r = 1'b1; tick(); a_r = 1'b0;
        n_chk++; if (a_obs !== 7'b0001_00_0) begin n_err++; $display("FAIL in_order_restart: got %b want %b", a_obs, 7'b0001_00_0); end
    endtask

    task automatic test_reverse();
        a_ev = 2'b10; tick();
        n_chk++; if (a_obs !== 7'b0010_10_0) begin n_err++; $display("FAIL reverse_collect: got %b want %b", a_obs, 7'b0010_10_0); end
        a_ev = 2'b01; tick();
        n_chk++; if (a_obs !== 7'b0100_11_1) begin n_err++; $display("FAIL reverse_emit: got %b want %b", a_obs, 7'b0100_11_1); end
        a_ev = 2'b00; tick();
        n_chk++; if (a_obs !== 7'b1000_11_0) begin n_err++; $display("FAIL reverse_done: got %b want %b", a_obs, 7'b1000_11_0); end
        a_r = 1'b1; tick(); a_r = 1'b0;
        n_chk++; if (a_obs !== 7'b0001_00_0) begin n_err++; $display("FAIL reverse_restart: got %b want %b", a_obs, 7'b0001_00_0); end
    endtask

    task automatic test_simultaneous();
        a_ev = 2'b11; tick();
        n_chk++; if (a_obs !== 7'b0100_11_1) begin n_err++; $display("FAIL simul_emit: got %b want %b", a_obs, 7'b0100_11_1); end
        tick();
        n_chk++; if (a_obs !== 7'b1000_11_0) begin n_err++; $display("FAIL simul_done: got %b want %b", a_obs, 7'b1000_11_0); end
        tick();
        n_chk++; if (a_obs !== 7'b1000_11_0) begin n_err++; $display("FAIL simul_done_held: got %b want %b", a_obs, 7'b1000_11_0); end
        a_ev = 2'b00; a_r = 1'b1; tick(); a_r = 1'b0;
        n_chk++; if (a_obs !== 7'b0001_00_0) begin n_err++; $display("FAIL simul_restart: got %b want %b", a_obs, 7'b0001_00_0); end
    endtask

    task automatic test_ordered();
        b_ev = 3'b100; tick();
        n_chk++; if (b_obs !== 8'b0001_000_0) begin n_err++; $display("FAIL ordered_skip_idle: got %b want %b", b_obs, 8'b0001_000_0); end
        b_ev = 3'b001; tick();
        n_chk++; if (b_obs !== 8'b0010_001_0) begin n_err++; $display("FAIL ordered_first: got %b want %b", b_obs, 8'b0010_001_0); end
        b_ev = 3'b100; tick();
        n_chk++; if (b_obs !== 8'b0010_001_0) begin n_err++; $display("FAIL ordered_skip_collect: got %b want %b", b_obs, 8'b0010_001_0); end
        b_ev = 3'b010; tick();
        n_chk++; if (b_obs !== 8'b0010_011_0) begin n_err++; $display("FAIL ordered_second: got %b want %b", b_obs, 8'b0010_011_0); end
        b_ev = 3'b100; tick();
        n_chk++; if (b_obs !== 8'b0100_111_1) begin n_err++; $display("FAIL ordered_emit: got %b want %b", b_obs, 8'b0100_111_1); end
        b_ev = 3'b000; tick();
        n_chk++; if (b_obs !== 8'b1000_111_1) begin n_err++; $display("FAIL ordered_done_hold: got %b want %b", b_obs, 8'b1000_111_1); end
        tick();
        n_chk++; if (b_obs !== 8'b1000_111_1) begin n_err++; $display("FAIL ordered_done_hold2: got %b want %b", b_obs, 8'b1000_111_1); end
        b_r = 1'b1; tick(); b_r = 1'b0;
        n_chk++; if (b_obs !== 8'b0001_000_0) begin n_err++; $display("FAIL ordered_restart: got %b want %b", b_obs, 8'b0001_000_0); end
    endtask

    task automatic test_back_to_back();
        // ordered mode accepts only one event per cycle even with all held high
        b_ev = 3'b111; tick();
        n_chk++; if (b_obs !== 8'b0010_001_0) begin n_err++; $display("FAIL b2b_step1: got %b want %b", b_obs, 8'b0010_001_0); end
        tick();
        n_chk++; if (b_obs !== 8'b0010_011_0) begin n_err++; $display("FAIL b2b_step2: got %b want %b", b_obs, 8'b0010_011_0); end
        tick();
        n_chk++; if (b_obs !== 8'b0100_111_1) begin n_err++; $display("FAIL b2b_emit: got %b want %b", b_obs, 8'b0100_111_1); end
        tick();
        n_chk++; if (b_obs !== 8'b1000_111_1) begin n_err++; $display("FAIL b2b_done: got %b want %b", b_obs, 8'b1000_111_1); end
        b_ev = 3'b000; b_r = 1'b1; tick(); b_r = 1'b0;
    endtask

    task automatic test_restart_priority();
        a_ev = 2'b01; tick();
        n_chk++; if (a_obs !== 7'b0010_01_0) begin n_err++; $display("FAIL rprio_collect: got %b want %b", a_obs, 7'b0010_01_0); end
        a_ev = 2'b10; a_r = 1'b1; tick();
        n_chk++; if (a_obs !== 7'b0001_00_0) begin n_err++; $display("FAIL rprio_with_event: got %b want %b", a_obs, 7'b0001_00_0); end
        a_r = 1'b0; a_ev = 2'b00; tick();
        n_chk++; if (a_obs !== 7'b0001_00_0) begin n_err++; $display("FAIL rprio_no_emit: got %b want %b", a_obs, 7'b0001_00_0); end
    endtask

    task automatic test_async_reset();
        a_ev = 2'b01; b_ev = 3'b001; tick();
        n_chk++; if (a_obs !== 7'b0010_01_0) begin n_err++; $display("FAIL areset_pre: got %b want %b", a_obs, 7'b0010_01_0); end
        reset_n = 1'b0;
        #1;
        n_chk++; if (a_obs !== 7'b0001_00_0) begin n_err++; $display("FAIL areset_immediate_a: got %b want %b", a_obs, 7'b0001_00_0); end
        n_chk++; if (b_obs !== 8'b0001_000_0) begin n_err++; $display("FAIL areset_immediate_b: got %b want %b", b_obs, 8'b0001_000_0); end
        a_ev = 2'b10; b_ev = 3'b010; tick();
        n_chk++; if (a_obs !== 7'b0001_00_0) begin n_err++; $display("FAIL areset_held: got %b want %b", a_obs, 7'b0001_00_0); end
        reset_n = 1'b1; a_ev = 2'b00; b_ev = 3'b000; tick();
        n_chk++; if (a_obs !== 7'b0001_00_0) begin n_err++; $display("FAIL areset_after: got %b want %b", a_obs, 7'b0001_00_0); end
    endtask

`ifdef ABRO_TIMEOUT_EN
    task automatic test_timeout();
        a_ev = 2'b01; tick();
        a_ev = 2'b00;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++; if ({a_obs, a_tmo} !== 8'b0010_01_0_0) begin n_err++; $display("FAIL tmo_wait%0d: got %b want %b", i, {a_obs, a_tmo}, 8'b0010_01_0_0); end
        end
        tick();
        n_chk++; if ({a_obs, a_tmo} !== 8'b0001_00_0_1) begin n_err++; $display("FAIL tmo_fire: got %b want %b", {a_obs, a_tmo}, 8'b0001_00_0_1); end
        tick();
        n_chk++; if ({a_obs, a_tmo} !== 8'b0001_00_0_0) begin n_err++; $display("FAIL tmo_one_cycle: got %b want %b", {a_obs, a_tmo}, 8'b0001_00_0_0); end
        a_ev = 2'b01; tick();
        a_ev = 2'b00; tick(); tick(); tick();
        a_ev = 2'b10; tick();
        n_chk++; if ({a_obs, a_tmo} !== 8'b0100_11_1_0) begin n_err++; $display("FAIL tmo_complete_wins: got %b want %b", {a_obs, a_tmo}, 8'b0100_11_1_0); end
        a_ev = 2'b00; a_r = 1'b1; tick(); a_r = 1'b0;
    endtask
`endif

    task automatic test_random(input int cycles);
        model_t ma;
        model_t mb;
        logic [6:0] ea;
        logic [7:0] eb;
        a_ev = 2'b00; b_ev = 3'b000; a_r = 1'b1; b_r = 1'b1;
        tick();
        a_r = 1'b0; b_r = 1'b0;
        ma = model_init(2, 1'b0, 1'b1, TLIM_A);
        mb = model_init(3, 1'b1, 1'b0, TLIM_B);
        for (int c = 0; c < cycles; c++) begin
            a_r = ($urandom_range(0, 24) == 0);
            b_r = ($urandom_range(0, 24) == 0);
            a_ev = ($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom_range(0, 3));
            b_ev = 3'($urandom_range(0, 7));
            tick();
            ma = model_step(ma, a_r, 16'(a_ev));
            mb = model_step(mb, b_r, 16'(b_ev));
            ea = {exp_state(ma), ma.got[1:0], exp_o(ma)};
            eb = {exp_state(mb), mb.got[2:0], exp_o(mb)};
            n_chk++; if (a_obs !== ea) begin n_err++; $display("FAIL random_a cycle %0d: got %b want %b", c, a_obs, ea); end
            n_chk++; if (b_obs !== eb) begin n_err++; $display("FAIL random_b cycle %0d: got %b want %b", c, b_obs, eb); end
`ifdef ABRO_TIMEOUT_EN
            n_chk++; if (a_tmo !== ma.tmo) begin n_err++; $display("FAIL random_tmo_a cycle %0d: got %b want %b", c, a_tmo, ma.tmo); end
            n_chk++; if (b_tmo !== mb.tmo) begin n_err++; $display("FAIL random_tmo_b cycle %0d: got %b want %b", c, b_tmo, mb.tmo); end
`endif
        end
        a_r = 1'b0; b_r = 1'b0; a_ev = 2'b00; b_ev = 3'b000;
    endtask

    // sequence and final report
    initial begin
        test_reset();
        test_in_order();
        test_reverse();
        test_simultaneous();
        test_ordered();
        test_back_to_back();
        test_restart_priority();
        test_async_reset();
`ifdef ABRO_TIMEOUT_EN
        test_timeout();
`endif
        test_random(400);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/abro_n_fsm.md
Name: abro_n_fsm

Overview:
- Parametrised successor of the two-input ABRO controller.
- Waits until every one of N event inputs has been seen since the last restart, then emits O. Events are accepted in any order or in a fixed index order, selected by parameter.
- Restarts on R. Sits in control paths as a "wait for all of N conditions" sequencer. Exposes one-hot state and a seen-mask for debug and checking.

Parameters:
N, 2, number of event inputs (legal 2..16)
ORDERED, 0, 0 = events accepted in any order; 1 = events must arrive in index order 0,1,..,N-1
O_PULSE, 1, 1 = O high for exactly one cycle on completion; 0 = O held high until restart
TIMEOUT_CYCLES, 255, COLLECT-state timeout limit; used only with ABRO_TIMEOUT_EN (legal 1..65535)

Ports:
clk  input  1  clock, all state changes on rising edge
reset_n  input  1  asynchronous active-low reset
R  input  1  synchronous restart, highest functional priority
ev  input  N  event inputs, sampled each rising edge, level-sensitive
O  output  1  completion output, registered
State  output  4  one-hot state: 0001 IDLE, 0010 COLLECT, 0100 EMIT, 1000 DONE
seen  output  N  bit k set = event k accepted since last restart
timeout  output  1  one-cycle timeout flag (exists only with ABRO_TIMEOUT_EN)

Behaviour:
- Async reset (reset_n low): State=0001, seen=0, O=0, timeout=0, timeout counter=0. These values hold while reset_n is low.
- All outputs are driven directly from flops. There is no combinational path from ev or R to any output.
- R high at an edge, in any state:
  - Next State=IDLE, seen=0, O=0, counter=0.
  - Events sampled in the same cycle are discarded.
- Accepted set per cycle:
  - ORDERED=0: acc = ev & ~seen.
  - ORDERED=1: let k = popcount(seen). acc = bit k only, if ev[k]=1. At most one event is accepted per cycle. Any other ev bits are ignored, with no error and no state change.
- seen_next = seen | acc, in IDLE and COLLECT only.
- IDLE: acc nonzero moves to COLLECT. If seen_next is all ones, go to EMIT instead (unordered, all N bits high in one cycle).
- COLLECT: stay until seen_next is all ones, then go to EMIT.
- EMIT: lasts exactly one cycle, with O=1. Next state is DONE.
- DONE:
  - O=0 if O_PULSE=1; O=1 if O_PULSE=0.
  - Events are ignored and seen stays all ones.
  - Stays in DONE until R.
- Latency: the edge that samples the completing event also sets State=0100 and O=1, visible right after that edge.
- Events held high across cycles count once. Events already in seen are never re-counted.
- Reset mid-operation (async) overrides everything immediately. The machine restarts from IDLE.
- Unused State encodings recover to IDLE on the next edge, with seen=0 and O=0.

Optional Feature:
Macro ABRO_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to COLLECT and increments each cycle while in COLLECT.
  - When the counter reaches TIMEOUT_CYCLES and the FSM is not completing in that cycle: next State=IDLE, seen=0, timeout=1 for one cycle.
  - Completion in the same cycle as the limit wins: go to EMIT, no timeout.
  - R in the same cycle as the limit wins: no timeout pulse.
- Undefined: no counter, no timeout port, and COLLECT waits indefinitely.

Test Plan:
- N=2, ORDERED=0, O_PULSE=1: ev=00, then 01, then 10. Required State: 0001 → 0010 → 0100 with O=1. Next cycle State=1000, O=0, seen=11.
- Same configuration: ev=10, then 01 (reverse order). Required response: EMIT after the second edge, O=1 for one cycle. Then R=1 gives State=0001, seen=00, O=0.
- Same configuration: ev=11 from IDLE. Required response: State goes 0001 → 0100 in one edge. Then ev=11 held while in DONE: O stays 0 and State stays 1000.
- N=3, ORDERED=1: ev=100 (ignored, State=0001), then 001 (seen=001), 100 (ignored), 010 (seen=011), 100 (EMIT, O=1). With O_PULSE=0, O stays 1 in DONE until R.
- R asserted together with the completing event in COLLECT, and reset_n pulsed low mid-COLLECT. Required response in both cases: State=0001, seen=0, O=0, and no EMIT.
- With ABRO_TIMEOUT_EN, TIMEOUT_CYCLES=4, N=2: ev=01, then ev=00 for 4 cycles. Required response: timeout=1 for one cycle and State=0001.
  - Repeat with ev=10 on the limit cycle: required EMIT and timeout=0.
